// File: rtl/uart_msg_gen.sv
// UART stimulus source: periodic fixed message plus buffered echo of received bytes.
// Latency: message starts 1 cycle after the timer saturates; echo leaves 1 cycle after a byte is stored.
// Backpressure: tx_dat/tx_wr_ev hold until tx_ready; full echo FIFO drops bytes and pulses rx_ovf.
module uart_msg_gen #(
  parameter int                   MSG_LEN    = 38,
  parameter logic [8*MSG_LEN-1:0] MSG        = "sapiens:a brief history of humankind\r\n",
  parameter int                   PERIOD     = 100_000_000,
  parameter int                   FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    mode,
  input  logic [7:0]                    rx_dat,
  input  logic                          rx_dat_ev,
  input  logic                          tx_ready,
  output logic [7:0]                    tx_dat,
  output logic                          tx_wr_ev,
  output logic                          busy,
  output logic                          rx_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TMR_W = $clog2(PERIOD);
  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_MSG  = 2'd1,
    S_ECHO = 2'd2
  } state_e;

  state_e             state_q;
  logic [TMR_W-1:0]   timer_q;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         tx_dat_q;
  logic               tx_wr_ev_q;
  logic               rx_ovf_q;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;

  // Message bytes unpacked so byte 0 is the leftmost character of the string.
  logic [7:0] msg_bytes [MSG_LEN];
  for (genvar g = 0; g < MSG_LEN; g++) begin : g_msg
    assign msg_bytes[g] = MSG[8*(MSG_LEN-1-g) +: 8];
  end

  logic             in_wait;
  logic             msg_due;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             drop;
  logic             xfer;
  logic [7:0]       fifo_head;
  logic [IDX_W-1:0] idx_nxt;
  logic [TMR_W-1:0] timer_inc;

  assign in_wait    = (state_q == S_WAIT);
  assign msg_due    = in_wait && (timer_q == TMR_MAX) && mode[0];
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_FULL);
  // The message has priority: a pop only happens on a WAIT cycle that is not starting one.
  assign pop        = in_wait && !msg_due && mode[1] && !fifo_empty;
  assign push_req   = rx_dat_ev && mode[1];
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && !push;
  assign xfer       = tx_wr_ev_q && tx_ready;
  assign fifo_head  = mem_q[rd_ptr_q];
  assign idx_nxt    = idx_q + IDX_W'(1);
  assign timer_inc  = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);

  // FIFO next-state: pointers wrap naturally on a power-of-2 depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
  end

  // FIFO storage; contents need no reset since the level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_dat;
  end

  // FIFO pointers, occupancy and the registered overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rx_ovf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rx_ovf_q <= drop;
    end
  end

  // Control FSM with registered tx outputs, period timer and message index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_WAIT;
      timer_q    <= '0;
      idx_q      <= '0;
      tx_dat_q   <= '0;
      tx_wr_ev_q <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          timer_q <= timer_inc;
          if (msg_due) begin
            tx_dat_q   <= msg_bytes[0];
            tx_wr_ev_q <= 1'b1;
            idx_q      <= '0;
            state_q    <= S_MSG;
          end else if (pop) begin
            tx_dat_q   <= fifo_head;
            tx_wr_ev_q <= 1'b1;
            state_q    <= S_ECHO;
          end
        end
        S_MSG: begin
          // Timer is frozen for the whole message and restarts from its last byte.
          if (xfer) begin
            if (idx_q == IDX_LAST) begin
              tx_wr_ev_q <= 1'b0;
              timer_q    <= '0;
              state_q    <= S_WAIT;
            end else begin
              idx_q    <= idx_nxt;
              tx_dat_q <= msg_bytes[idx_nxt];
            end
          end
        end
        S_ECHO: begin
          timer_q <= timer_inc;
          if (xfer) begin
            tx_wr_ev_q <= 1'b0;
            state_q    <= S_WAIT;
          end
        end
        default: begin
          tx_wr_ev_q <= 1'b0;
          state_q    <= S_WAIT;
        end
      endcase
    end
  end

  assign tx_dat     = tx_dat_q;
  assign tx_wr_ev   = tx_wr_ev_q;
  assign busy       = !in_wait;
  assign rx_ovf     = rx_ovf_q;
  assign fifo_level = level_q;

endmodule
